// File: rtl/ps2_key_tracker_pkg.sv
// Shared constants, FSM state type and frame check for the PS/2 key tracker.
package ps2_pkg;
  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {IDLE, PRESSED, BREAK, BREAK_IDLE} key_state_e;

  // Frame bit 0 is start, 8:1 data (LSB first), 9 odd parity, 10 stop.
  function automatic logic frame_ok(input logic [10:0] f);
    return ~f[0] & f[10] & (^f[9:1]);
  endfunction
endpackage

// File: rtl/ps2_key_tracker_if.sv
// Pin/display bundle between the keyboard pins, the tracker and the decoder.
interface ps2_key_tracker_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scancode;
  logic [7:0] key_count;
  logic       seg_en;
  logic       frame_err;
  logic       overflow;

  modport master (output ps2_clk, ps2_data,
                  input  scancode, key_count, seg_en, frame_err, overflow);
  modport slave  (input  ps2_clk, ps2_data,
                  output scancode, key_count, seg_en, frame_err, overflow);
endinterface

// File: rtl/ps2_key_tracker_rx.sv
// PS/2 frame receiver: synchronisers, falling-edge sampling, frame check and
// partial-frame timeout. byte_valid_o is combinational in the edge cycle so
// the FIFO write lands at the end of that same cycle.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          frame_err_q, frame_err_d;
  logic          fall;
  logic [10:0]   frame;

  // Synchronisers reset low so a line already high after reset never looks
  // like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '0;
      dat_sync_q <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
    end
  end

  assign fall  = clk_sync_q[2] & ~clk_sync_q[1];
  assign frame = {dat_sync_q[1], shift_q};

  // Bit counting, shifting, end-of-frame check and idle timeout.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    idle_d       = idle_q;
    frame_err_d  = 1'b0;
    byte_valid_o = 1'b0;
    if (fall) begin
      idle_d = '0;
      if (bit_cnt_q == 4'(PS2_FRAME_BITS - 1)) begin
        bit_cnt_d    = '0;
        byte_valid_o = frame_ok(frame);
        frame_err_d  = ~frame_ok(frame);
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {dat_sync_q[1], shift_q[9:1]};
      end
    end else if (bit_cnt_q != '0) begin
      if (idle_q == TW'(TIMEOUT - 1)) begin
        bit_cnt_d = '0;
        idle_d    = '0;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      idle_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      idle_q      <= idle_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign byte_data_o = frame[8:1];
  assign frame_err_o = frame_err_q;
endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: receiver, byte FIFO and make/break tracking FSM
// feeding the seven-segment decoder.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 50000
) (
  input logic               clk,
  input logic               rst_n,
  ps2_key_tracker_if.slave  bus
);
  localparam int           AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  PTR_ONE = (AW + 1)'(1);
  localparam logic [AW:0]  PTR_MSB = {1'b1, {AW{1'b0}}};

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .ps2_clk_i    (bus.ps2_clk),
    .ps2_data_i   (bus.ps2_data),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .frame_err_o  (frame_err)
  );

  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        full, empty, pop, push;
  logic [7:0]  rd_byte;

  assign full    = (wr_q ^ rd_q) == PTR_MSB;
  assign empty   = wr_q == rd_q;
  assign pop     = ~empty;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push    = byte_valid & (~full | pop);
  assign rd_byte = mem_q[rd_q[AW-1:0]];

  // FIFO storage needs no reset; emptiness is carried by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= byte_data;
  end

  logic ovf_q;

  // FIFO pointers and the sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + PTR_ONE;
      if (pop)  rd_q <= rd_q + PTR_ONE;
      if (byte_valid & ~push) ovf_q <= 1'b1;
    end
  end

  key_state_e state_q;
  logic [7:0] cur_q, scancode_q, count_q;
  logic       seg_en_q;

  // Key FSM: consumes one byte per cycle, extended prefix is transparent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      scancode_q <= '0;
      count_q    <= '0;
      seg_en_q   <= 1'b0;
    end else if (pop && rd_byte != PS2_EXT) begin
      case (state_q)
        IDLE: begin
          if (rd_byte == PS2_BREAK) begin
            state_q <= BREAK_IDLE;
          end else begin
            scancode_q <= rd_byte;
            cur_q      <= rd_byte;
            count_q    <= count_q + 8'd1;
            seg_en_q   <= 1'b1;
            state_q    <= PRESSED;
          end
        end
        PRESSED: begin
          if (rd_byte == PS2_BREAK) begin
            state_q <= BREAK;
          end else if (rd_byte != cur_q) begin
            scancode_q <= rd_byte;
            cur_q      <= rd_byte;
            count_q    <= count_q + 8'd1;
          end
        end
        BREAK: begin
          if (rd_byte == cur_q) begin
            seg_en_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            state_q <= PRESSED;
          end
        end
        BREAK_IDLE: state_q <= IDLE;
        default:    state_q <= IDLE;
      endcase
    end
  end

  assign bus.scancode  = scancode_q;
  assign bus.key_count = count_q;
  assign bus.seg_en    = seg_en_q;
  assign bus.frame_err = frame_err;
  assign bus.overflow  = ovf_q;
endmodule
